// File: rtl/pipe_controller_rv32.sv
// RV32I decode-stage control with D->E->M->W control pipeline.
// Ports: decode inputs (op/funct3/funct7b5/ValidD), E-stage flags
//   (ZeroE/LtE/LtuE), hazard controls (StallE/FlushE), per-stage
//   control outputs, IllegalW and the retired-instruction counter.
module pipe_controller_rv32 #(
  parameter int ALU_CTRL_W   = 4,
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_KILL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ValidD,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  ZeroE,
  input  logic                  LtE,
  input  logic                  LtuE,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic                  ALUSrcAE,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ResultSrcE0,
  output logic                  PCSrcE,
  output logic                  JalrE,
  output logic                  MemWriteM,
  output logic                  RegWriteM,
  output logic [1:0]            ResultSrcW,
  output logic                  RegWriteW,
  output logic                  IllegalW,
  output logic [CNT_W-1:0]      InstRetCount
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       alu_src_a;
    logic [2:0] funct3;
  } ctrl_e_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc;
  logic legal_op, illegal_d;
  logic [3:0] alu_arith, alu_d;

  ctrl_e_t ctrl_d, e_q;
  ctrl_m_t m_d, m_q;
  ctrl_w_t w_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic br_cond;

  assign is_r     = (op == OP_R);
  assign is_i     = (op == OP_I);
  assign is_ld    = (op == OP_LOAD);
  assign is_st    = (op == OP_STORE);
  assign is_br    = (op == OP_BR);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);

  assign legal_op = is_r | is_i | is_ld | is_st | is_br
                  | is_jal | is_jalr | is_lui | is_auipc;

  // funct3 010/011 are unused branch encodings
  assign illegal_d = ~legal_op
                   | (is_jalr & (funct3 != 3'b000))
                   | (is_br & (funct3[2:1] == 2'b01));

  always_comb begin
    ImmSrcD = 3'b000;
    unique case (1'b1)
      is_st:            ImmSrcD = 3'b001;
      is_br:            ImmSrcD = 3'b010;
      is_jal:           ImmSrcD = 3'b011;
      is_lui, is_auipc: ImmSrcD = 3'b100;
      default:          ImmSrcD = 3'b000;
    endcase
  end

  // addi has no sub form: funct7b5 only matters for R-type 000
  always_comb begin
    alu_arith = ALU_ADD;
    unique case (funct3)
      3'b000: alu_arith = (is_r & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_arith = ALU_SLL;
      3'b010: alu_arith = ALU_SLT;
      3'b011: alu_arith = ALU_SLTU;
      3'b100: alu_arith = ALU_XOR;
      3'b101: alu_arith = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_arith = ALU_OR;
      3'b111: alu_arith = ALU_AND;
      default: alu_arith = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_d = ALU_ADD;
    unique case (1'b1)
      is_r, is_i: alu_d = alu_arith;
      is_br:      alu_d = ALU_SUB;
      default:    alu_d = ALU_ADD;
    endcase
  end

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = 1'b1;
    ctrl_d.illegal    = illegal_d;
    ctrl_d.reg_write  = is_r | is_i | is_ld | is_jal
                      | is_jalr | is_lui | is_auipc;
    ctrl_d.result_src = is_ld             ? 2'b01 :
                        (is_jal | is_jalr) ? 2'b10 :
                        is_lui            ? 2'b11 : 2'b00;
    ctrl_d.mem_write  = is_st;
    ctrl_d.jump       = is_jal | is_jalr;
    ctrl_d.jalr       = is_jalr;
    ctrl_d.branch     = is_br;
    ctrl_d.alu_ctrl   = alu_d;
    ctrl_d.alu_src    = is_i | is_ld | is_st | is_jalr
                      | is_lui | is_auipc;
    ctrl_d.alu_src_a  = is_auipc;
    ctrl_d.funct3     = funct3;
    if (ILLEGAL_KILL && illegal_d) begin
      ctrl_d.reg_write = 1'b0;
      ctrl_d.mem_write = 1'b0;
      ctrl_d.jump      = 1'b0;
      ctrl_d.jalr      = 1'b0;
      ctrl_d.branch    = 1'b0;
    end
    if (!ValidD) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q <= '0;
    end else if (!StallE) begin
      e_q <= ctrl_d;
    end
  end

  // a held E slot must not also advance into M
  always_comb begin
    m_d            = '0;
    m_d.valid      = e_q.valid;
    m_d.illegal    = e_q.illegal;
    m_d.reg_write  = e_q.reg_write;
    m_d.result_src = e_q.result_src;
    m_d.mem_write  = e_q.mem_write;
    if (StallE && !FlushE) begin
      m_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q.valid      <= m_q.valid;
      w_q.illegal    <= m_q.illegal;
      w_q.reg_write  <= m_q.reg_write;
      w_q.result_src <= m_q.result_src;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_q.valid && !w_q.illegal) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    br_cond = 1'b0;
    unique case (e_q.funct3)
      3'b000:  br_cond = ZeroE;
      3'b001:  br_cond = ~ZeroE;
      3'b100:  br_cond = LtE;
      3'b101:  br_cond = ~LtE;
      3'b110:  br_cond = LtuE;
      3'b111:  br_cond = ~LtuE;
      default: br_cond = 1'b0;
    endcase
  end

  assign PCSrcE = e_q.valid
                & (e_q.jump | (e_q.branch & br_cond));

  assign ALUSrcAE     = e_q.alu_src_a;
  assign ALUSrcE      = e_q.alu_src;
  assign ALUControlE  = ALU_CTRL_W'(e_q.alu_ctrl);
  assign ResultSrcE0  = e_q.result_src[0];
  assign JalrE        = e_q.jalr;
  assign MemWriteM    = m_q.mem_write;
  assign RegWriteM    = m_q.reg_write;
  assign ResultSrcW   = w_q.result_src;
  assign RegWriteW    = w_q.reg_write;
  assign IllegalW     = w_q.valid & w_q.illegal;
  assign InstRetCount = cnt_q;

endmodule

// File: tb/tb_pipe_controller_rv32.sv
// Bench for pipe_controller_rv32: directed + random stimulus
// against a slot-based reference pipeline model.
module tb_pipe_controller_rv32;

  logic       clk;
  logic       reset;
  logic       ValidD;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       ZeroE, LtE, LtuE;
  logic       StallE, FlushE;
  logic [2:0] ImmSrcD;
  logic       ALUSrcAE, ALUSrcE;
  logic [3:0] ALUControlE;
  logic       ResultSrcE0, PCSrcE, JalrE;
  logic       MemWriteM, RegWriteM;
  logic [1:0] ResultSrcW;
  logic       RegWriteW, IllegalW;
  logic [3:0] InstRetCount;

  int checks = 0;
  int errors = 0;

  pipe_controller_rv32 #(
    .ALU_CTRL_W(4),
    .CNT_W(4),
    .ILLEGAL_KILL(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ValidD(ValidD),
    .op(op),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .ZeroE(ZeroE),
    .LtE(LtE),
    .LtuE(LtuE),
    .StallE(StallE),
    .FlushE(FlushE),
    .ImmSrcD(ImmSrcD),
    .ALUSrcAE(ALUSrcAE),
    .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE),
    .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE),
    .JalrE(JalrE),
    .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM),
    .ResultSrcW(ResultSrcW),
    .RegWriteW(RegWriteW),
    .IllegalW(IllegalW),
    .InstRetCount(InstRetCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam bit [6:0] R   = 7'b0110011;
  localparam bit [6:0] I   = 7'b0010011;
  localparam bit [6:0] LD  = 7'b0000011;
  localparam bit [6:0] ST  = 7'b0100011;
  localparam bit [6:0] BR  = 7'b1100011;
  localparam bit [6:0] JAL = 7'b1101111;
  localparam bit [6:0] JR  = 7'b1100111;
  localparam bit [6:0] LUI = 7'b0110111;
  localparam bit [6:0] AUI = 7'b0010111;

  typedef struct packed {
    bit       v;
    bit       ill;
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit       jmp;
    bit       jalr;
    bit       br;
    bit [3:0] alu;
    bit       asrc;
    bit       asrca;
    bit [2:0] f3;
  } mctl_t;

  mctl_t se, sm, sw;
  int    cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit [3:0] alu_ref(bit [2:0] f, bit f7, bit isr);
    case (f)
      3'd0: return (isr && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic bit [2:0] imm_ref(bit [6:0] o);
    if (o == ST) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI || o == AUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic mctl_t dec_ref(bit v, bit [6:0] o,
                                    bit [2:0] f, bit f7);
    mctl_t c = '0;
    bit known, bad;
    known = (o == R) || (o == I) || (o == LD) || (o == ST)
         || (o == BR) || (o == JAL) || (o == JR)
         || (o == LUI) || (o == AUI);
    bad = !known || (o == JR && f != 3'd0)
       || (o == BR && (f == 3'd2 || f == 3'd3));
    if (!v) return c;
    c.v     = 1'b1;
    c.ill   = bad;
    c.f3    = f;
    if (o == R || o == I) c.alu = alu_ref(f, f7, o == R);
    if (o == BR) c.alu = 4'd1;
    c.rw    = known && o != ST && o != BR;
    c.rs    = (o == LD) ? 2'd1 :
              (o == JAL || o == JR) ? 2'd2 :
              (o == LUI) ? 2'd3 : 2'd0;
    c.mw    = (o == ST);
    c.jmp   = (o == JAL || o == JR);
    c.jalr  = (o == JR);
    c.br    = (o == BR);
    c.asrc  = known && o != R && o != BR && o != JAL;
    c.asrca = (o == AUI);
    if (bad) begin
      c.rw = 0; c.mw = 0; c.jmp = 0; c.jalr = 0; c.br = 0;
    end
    return c;
  endfunction

  function automatic bit taken(bit [2:0] f, bit z, bit lt, bit ltu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_outs();
    bit pc;
    pc = se.v && (se.jmp || (se.br && taken(se.f3, ZeroE, LtE, LtuE)));
    chk("ImmSrcD", 32'(ImmSrcD), 32'(imm_ref(op)));
    chk("ALUSrcAE", 32'(ALUSrcAE), 32'(se.asrca));
    chk("ALUSrcE", 32'(ALUSrcE), 32'(se.asrc));
    chk("ALUControlE", 32'(ALUControlE), 32'(se.alu));
    chk("ResultSrcE0", 32'(ResultSrcE0), 32'(se.rs[0]));
    chk("PCSrcE", 32'(PCSrcE), 32'(pc));
    chk("JalrE", 32'(JalrE), 32'(se.jalr));
    chk("MemWriteM", 32'(MemWriteM), 32'(sm.mw));
    chk("RegWriteM", 32'(RegWriteM), 32'(sm.rw));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(sw.rs));
    chk("RegWriteW", 32'(RegWriteW), 32'(sw.rw));
    chk("IllegalW", 32'(IllegalW), 32'(sw.v && sw.ill));
    chk("InstRetCount", 32'(InstRetCount), 32'(cnt));
  endtask

  task automatic cyc(input bit v, input bit [6:0] o,
                     input bit [2:0] f, input bit f7,
                     input bit st, input bit fl,
                     input bit z, input bit lt, input bit ltu);
    @(negedge clk);
    ValidD = v; op = o; funct3 = f; funct7b5 = f7;
    StallE = st; FlushE = fl;
    ZeroE = z; LtE = lt; LtuE = ltu;
    #1 check_outs();
    @(posedge clk);
    if (sw.v && !sw.ill) cnt = (cnt + 1) % 16;
    sw = sm;
    sm = (st && !fl) ? mctl_t'(0) : se;
    if (fl) se = '0;
    else if (!st) se = dec_ref(v, o, f, f7);
  endtask

  task automatic ins(input bit [6:0] o, input bit [2:0] f,
                     input bit f7);
    cyc(1, o, f, f7, 0, 0, 0, 0, 0);
  endtask

  task automatic bub(input int n);
    for (int k = 0; k < n; k++) cyc(0, R, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_cycles(input int n);
    bit [6:0] ops [12];
    ops = '{R, I, LD, ST, BR, JAL, JR, LUI, AUI,
            7'b1110011, 7'b0001111, 7'b1111111};
    for (int k = 0; k < n; k++) begin
      bit [6:0] o;
      int idx;
      idx = int'($urandom_range(0, 12));
      o = (idx == 12) ? 7'($urandom) : ops[idx];
      cyc($urandom_range(0, 7) != 0, o, 3'($urandom), 1'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    ValidD = 1'b1; op = R; funct3 = 3'd0; funct7b5 = 1'b0;
    StallE = 1'b0; FlushE = 1'b0;
    #2 reset = 1'b0;
    se = '0; sm = '0; sw = '0; cnt = 0;
    #1 check_outs();
    op = LUI;
    #1 chk("ImmSrcD_rst", 32'(ImmSrcD), 32'(3'b100));
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    ValidD = 0; op = '0; funct3 = '0; funct7b5 = 0;
    ZeroE = 0; LtE = 0; LtuE = 0; StallE = 0; FlushE = 0;
    se = '0; sm = '0; sw = '0; cnt = 0;
    repeat (2) @(negedge clk);
    #1 check_outs();
    reset = 1'b1;

    ins(R, 3'd0, 1'b0);
    ins(R, 3'd0, 1'b1);
    bub(4);

    cyc(1, BR, 3'd5, 0, 0, 0, 0, 0, 0);
    cyc(1, BR, 3'd5, 0, 0, 0, 0, 0, 0);
    cyc(1, BR, 3'd6, 0, 0, 0, 0, 1, 0);
    cyc(0, R, 3'd0, 0, 0, 0, 0, 0, 1);
    bub(3);

    ins(JR, 3'd0, 1'b0);
    ins(JR, 3'd1, 1'b0);
    bub(4);

    ins(LD, 3'd2, 1'b0);
    cyc(1, R, 3'd0, 0, 1, 0, 0, 0, 0);
    cyc(1, R, 3'd0, 0, 0, 0, 0, 0, 0);
    bub(4);

    cyc(1, BR, 3'd0, 0, 0, 0, 1, 0, 0);
    cyc(1, R, 3'd0, 0, 1, 1, 1, 0, 0);
    cyc(0, R, 3'd0, 0, 0, 0, 1, 0, 0);
    bub(3);

    for (int k = 0; k < 17; k++) ins(R, 3'd0, 1'b0);
    bub(4);

    ins(LUI, 3'd0, 0);
    ins(AUI, 3'd0, 0);
    ins(I, 3'd5, 1);
    ins(I, 3'd0, 1);
    ins(ST, 3'd2, 0);
    ins(JAL, 3'd0, 0);
    ins(7'b1110011, 3'd0, 0);
    ins(R, 3'd0, 0);
    mid_reset();
    bub(2);

    rnd_cycles(400);
    mid_reset();
    rnd_cycles(300);
    bub(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
